// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO result registers
// Ports:
//   CLK, nRST          clock, asynchronous active-low reset
//   start, op          request and operation (00 MULTU, 01 MULT, 10 DIVU, 11 DIV), sampled in IDLE
//   portA, portB       multiplicand/dividend and multiplier/divisor, captured with start
//   flush              abort the operation in flight; blocks start in IDLE
//   busy, done         unit occupied / one-cycle result-valid pulse
//   hi, lo             product halves, or remainder / quotient
//   div_zero           last completed divide had a zero divisor
module alu_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] portA,
    input  logic [WIDTH-1:0] portB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, prod;
    logic [WIDTH-1:0]   m_q, m_d, hi_q, hi_d, lo_q, lo_d, mag_a, mag_b;
    logic [WIDTH:0]     add_s, sub_s;
    logic               div_q, div_d, dz_q, dz_d, sq_q, sq_d, sr_q, sr_d, dzf_q, dzf_d;
    always_comb begin
        mag_a   = (op[0] && portA[WIDTH-1]) ? -portA : portA;
        mag_b   = (op[0] && portB[WIDTH-1]) ? -portB : portB;
        // multiply: acc = {partial sum, remaining multiplier bits}, shifted right each step
        add_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
        // divide: acc = {remainder, dividend/quotient bits}, shifted left each step
        sub_s   = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, m_q};
        prod    = sq_q ? -acc_q : acc_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div_d   = div_q;
        dz_d    = dz_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        dzf_d   = dzf_q;
        case (state_q)
            IDLE: if (start && !flush) begin
                state_d = RUN;
                cnt_d   = '0;
                div_d   = op[1];
                dz_d    = op[1] && portB == '0;
                sq_d    = op[0] && (portA[WIDTH-1] ^ portB[WIDTH-1]);
                sr_d    = op[0] && portA[WIDTH-1];
                m_d     = op[1] ? mag_b : mag_a;
                // a zero divisor preloads the final hi/lo values directly
                acc_d   = (op[1] && portB == '0) ? {portA, {WIDTH{1'b1}}}
                                                 : {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
            end
            RUN: if (dz_q) begin
                state_d = DONE;
                hi_d    = acc_q[2*WIDTH-1:WIDTH];
                lo_d    = acc_q[WIDTH-1:0];
                dzf_d   = 1'b1;
            end else begin
                acc_d   = !div_q ? {add_s, acc_q[WIDTH-1:1]}
                        : sub_s[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                        : {sub_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? FIX : RUN;
            end
            FIX: begin
                state_d = DONE;
                dzf_d   = 1'b0;
                hi_d    = !div_q ? prod[2*WIDTH-1:WIDTH]
                        : sr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                lo_d    = !div_q ? prod[WIDTH-1:0]
                        : sq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            end
            default: state_d = IDLE;
        endcase
        // a squashed operation leaves the previous results untouched
        if (flush) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            dzf_d   = dzf_q;
        end
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            dz_q    <= 1'b0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            dzf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div_q   <= div_d;
            dz_q    <= dz_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            dzf_q   <= dzf_d;
        end
    end
    assign busy     = state_q != IDLE;
    assign done     = state_q == DONE && !flush;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = dzf_q;
endmodule

// File: tb/tb_alu_muldiv_unit.sv
// tb_alu_muldiv_unit: directed vectors checked against literals and an arithmetic reference model
module tb_alu_muldiv_unit;
    localparam int W = 32;
    logic         CLK = 0, nRST = 0, start = 0, flush = 0;
    logic [1:0]   op = 0;
    logic [W-1:0] portA = 0, portB = 0, hi, lo;
    logic         busy, done, div_zero;
    logic         start8 = 0, busy8, done8, dz8;
    logic [7:0]   a8 = 0, b8 = 0, hi8, lo8;

    always #5 CLK = ~CLK;

    alu_muldiv_unit #(.WIDTH(W)) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .op(op), .portA(portA), .portB(portB),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero));

    alu_muldiv_unit #(.WIDTH(8)) dut8 (
        .CLK(CLK), .nRST(nRST), .start(start8), .op(2'b00), .portA(a8), .portB(b8),
        .flush(1'b0), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_zero(dz8));

    typedef struct {int dc; logic [W-1:0] h; logic [W-1:0] l; logic z;} exp_t;
    exp_t         q[$];
    exp_t         e;
    int           cyc = 0, busy_end = -1, n_pass = 0, n_tot = 0;
    logic [W-1:0] c_hi = 0, c_lo = 0;
    logic         c_dz = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Result and done cycle of an op whose start is sampled at the end of cycle s
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input int s);
        exp_t        r;
        logic [63:0] p;
        longint      sa, sb;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        r.z = 1'b0;
        if (o[1] && b == 0) begin
            r.h  = a;
            r.l  = '1;
            r.z  = 1'b1;
            r.dc = s + 2;
        end else begin
            r.dc = s + W + 2;
            case (o)
                2'd0:    p = {32'd0, a} * {32'd0, b};
                2'd1:    p = 64'(sa * sb);
                2'd2:    p = {a % b, a / b};
                default: p = {32'(sa % sb), 32'(sa / sb)};
            endcase
            r.h = p[63:32];
            r.l = p[31:0];
        end
        return r;
    endfunction

    // Acceptance model: a start is taken in any cycle after the previous op's busy window
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            q.delete();
            busy_end = -1;
        end else begin
            if (flush && cyc <= busy_end) begin
                busy_end = cyc;
                q.delete();
            end else if (start && !flush && cyc > busy_end) begin
                e = model(op, portA, portB, cyc);
                q.push_back(e);
                busy_end = e.dc;
            end
            cyc++;
        end
    end

    always @(negedge CLK) begin
        logic m;
        if (!nRST) begin
            c_hi = '0;
            c_lo = '0;
            c_dz = 1'b0;
            chk("reset_hilo", {hi, lo}, 64'd0);
            chk("reset_flags", {61'd0, busy, done, div_zero}, 64'd0);
        end else begin
            m = q.size() > 0 && q[0].dc == cyc;
            if (m) begin
                c_hi = q[0].h;
                c_lo = q[0].l;
                c_dz = q[0].z;
                void'(q.pop_front());
            end
            chk("busy", busy, cyc <= busy_end);
            chk("done", done, m && !flush);
            chk("hi", hi, c_hi);
            chk("lo", lo, c_lo);
            chk("div_zero", div_zero, c_dz);
        end
    end

    task automatic op_lit(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el, input logic ez, input int lat);
        int k;
        @(posedge CLK); #1;
        start = 1; op = o; portA = a; portB = b;
        @(posedge CLK); #1;
        start = 0;
        k = 0;
        while (!done && k < 60) begin
            @(negedge CLK);
            k++;
        end
        chk("lit_latency", k, lat);
        chk("lit_hi", hi, eh);
        chk("lit_lo", lo, el);
        chk("lit_div_zero", div_zero, ez);
    endtask

    initial begin
        int k, nd;
        repeat (2) @(posedge CLK);
        #3 nRST = 1;
        op_lit(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 34);
        op_lit(2'b01, 32'hFFFFFFF9, 32'd6,        32'hFFFFFFFF, 32'hFFFFFFD6, 0, 34);
        op_lit(2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0, 34);
        op_lit(2'b10, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1, 2);
        op_lit(2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       0, 34);
        op_lit(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 0, 34);
        op_lit(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        0, 34);
        op_lit(2'b10, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 0, 34);
        op_lit(2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 0, 34);
        op_lit(2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1, 2);
        // flush mid-run: busy drops, results from the previous op survive
        @(posedge CLK); #1;
        start = 1; op = 2'b00; portA = 3; portB = 5;
        @(posedge CLK); #1;
        start = 0;
        repeat (9) @(posedge CLK);
        #1 flush = 1;
        @(posedge CLK); #1;
        flush = 0;
        @(negedge CLK);
        chk("flush_busy", busy, 0);
        repeat (40) @(negedge CLK);
        chk("flush_hi", hi, 5);
        chk("flush_lo", lo, 32'hFFFFFFFF);
        chk("flush_dz", div_zero, 1);
        // asynchronous reset mid-run
        @(posedge CLK); #1;
        start = 1; op = 2'b00; portA = 3; portB = 5;
        @(posedge CLK); #1;
        start = 0;
        repeat (5) @(posedge CLK);
        #3 nRST = 0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_hi", hi, 0);
        chk("async_rst_lo", lo, 0);
        chk("async_rst_dz", div_zero, 0);
        @(posedge CLK);
        #3 nRST = 1;
        // start held high: one result every 35 cycles
        @(posedge CLK); #1;
        start = 1; op = 2'b00; portA = 2; portB = 3;
        nd = 0;
        for (int i = 0; i < 105; i++) begin
            @(negedge CLK);
            if (done) begin
                nd++;
                chk("hold_lo", lo, 6);
            end
            if (i < 104) @(posedge CLK);
        end
        @(posedge CLK); #1;
        start = 0;
        chk("hold_done_count", nd, 3);
        // narrow instance
        @(posedge CLK); #1;
        start8 = 1; a8 = 8'h02; b8 = 8'h03;
        @(posedge CLK); #1;
        start8 = 0;
        k = 0;
        while (!done8 && k < 30) begin
            @(negedge CLK);
            k++;
        end
        chk("w8_latency", k, 10);
        chk("w8_lo", lo8, 8'h06);
        chk("w8_hi", hi8, 8'h00);
        repeat (3) @(posedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/alu_muldiv_unit.md
Name: alu_muldiv_unit

Overview:
- Parametrised, multi-cycle integer multiply/divide unit for the pipelined datapath.
- Sits beside the single-cycle ALU in EX and serves MULT/MULTU/DIV/DIVU.
- Results go into internal HI/LO registers.
- EX stalls on busy, and the unit raises a one-cycle done pulse when the results are valid.

Parameters:
- WIDTH, 32: operand width in bits. Must be ≥4 and even. HI and LO are each WIDTH bits.
- CNT_W, $clog2(WIDTH)+1: width of the iteration counter.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- nRST  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV. Captured with start.
- portA  input  WIDTH  multiplicand / dividend; captured with start.
- portB  input  WIDTH  multiplier / divisor; captured with start.
- flush  input  1  abort any operation in flight (branch/exception squash).
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle pulse: hi/lo/div_zero are valid.
- hi  output  WIDTH  product upper half, or remainder.
- lo  output  WIDTH  product lower half, or quotient.
- div_zero  output  1  last completed divide had portB==0. Held until the next done.

Behaviour:
- Reset (nRST low, asynchronous):
  - state=IDLE; busy=0, done=0, hi=0, lo=0, div_zero=0; counter and working registers cleared.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 and flush=0 → capture op/portA/portB, go to RUN, counter=0. busy rises next cycle.
  - start ignored in any other state; no queueing.
- Signed ops (MULT, DIV):
  - Operands are converted to magnitudes at capture.
  - Result sign is recorded: product sign = A[msb]^B[msb]; quotient sign = A[msb]^B[msb]; remainder sign = A[msb].
  - Unsigned ops record positive signs.
- RUN: exactly WIDTH cycles, one bit per cycle.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
  - Counter increments each cycle; at counter==WIDTH-1 → FIX.
- FIX: one cycle.
  - Apply the recorded signs by two's-complement negation: the 2·WIDTH product as a whole; quotient and remainder independently.
  - Write hi/lo. Go to DONE.
- DONE: done=1 for this single cycle, then IDLE.
  - busy is still 1 during DONE and falls the cycle after.
- Latency:
  - The start cycle is accepted at edge E0.
  - done is high in the cycle following edge E0+WIDTH+1, i.e. WIDTH+2 cycles after the start cycle.
  - Back-to-back ops: the next start is accepted in the first IDLE cycle after DONE.
- Divide by zero (DIV/DIVU with portB==0):
  - At capture, go straight to DONE on the next edge; no RUN/FIX.
  - hi=portA (unmodified), lo=all ones, div_zero=1.
- Overflow case DIV with portA=MIN (1 followed by zeros), portB=-1: lo=MIN, hi=0, div_zero=0. No trap.
- MULT of MIN×MIN: {hi,lo} = 2^(2·WIDTH-2). The result is exact; there is no overflow flag.
- div_zero is cleared to 0 at every non-divide-by-zero done.
- hi/lo/div_zero change only in FIX (or in DONE entry for divide by zero). Otherwise they hold their values.
- flush:
  - In RUN/FIX/DONE → IDLE on the next edge. hi/lo/div_zero keep their previous values; done is forced 0 that cycle.
  - In IDLE, flush blocks start in the same cycle.
  - flush has priority over start.
- Reset mid-operation: immediate return to reset values; no partial result is written.

Test Plan:
- WIDTH=32, MULTU A=0xFFFFFFFF B=0xFFFFFFFF → done exactly 34 cycles after the start cycle; hi=0xFFFFFFFE, lo=0x00000001; busy high 34 cycles.
- MULT A=-7 (0xFFFFFFF9) B=6 → hi=0xFFFFFFFF, lo=0xFFFFFFD6. Then DIV A=-7 B=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU A=100 B=0 → done 2 cycles after start, no RUN; hi=100, lo=0xFFFFFFFF, div_zero=1. A following DIVU 100/7 → lo=14, hi=2, div_zero=0.
- DIV A=0x80000000 B=0xFFFFFFFF → lo=0x80000000, hi=0, div_zero=0.
- Flush and reset:
  - Start MULTU 3×5, assert flush at RUN cycle 10 → busy drops next cycle, no done, hi/lo keep their prior values.
  - Repeat the op, then pulse nRST low mid-RUN → all outputs 0 asynchronously.
- Start held high continuously with A=2 B=3 MULTU → start is ignored while busy; results lo=6 arrive every 35 cycles (34 latency + 1 IDLE accept). A WIDTH=8 instance gives 0x02×0x03 → lo=0x06 in 10 cycles.
